// File: rtl/servo_seq_ctrl.sv
// servo_seq_ctrl: queued servo duty targets, slewed by STEP per frame then held; SERVO_AUTOSWEEP_EN adds an idle end-to-end sweep
module servo_seq_ctrl #(
  parameter int MIN_DUTY    = 25_000,
  parameter int MAX_DUTY    = 50_000,
  parameter int RESET_DUTY  = 37_500,
  parameter int STEP        = 250,
  parameter int HOLD_FRAMES = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [18:0]                   cmd_duty,
  output logic [18:0]                   duty,
  output logic                          busy,
  output logic                          at_target,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          led_verde,
  output logic                          led_verm
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(HOLD_FRAMES + 2);
  localparam logic [18:0] MIN_D  = 19'(MIN_DUTY);
  localparam logic [18:0] MAX_D  = 19'(MAX_DUTY);
  localparam logic [18:0] RST_D  = 19'(RESET_DUTY);
  localparam logic [18:0] MID_D  = 19'((MIN_DUTY + MAX_DUTY) / 2);
  localparam logic [18:0] STEP_D = 19'(STEP);
  localparam logic [HW-1:0] HOLD_N = HW'(HOLD_FRAMES);
  localparam logic [LW-1:0] FULL_N = LW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_t;
  state_t state_q, state_d;
  logic [18:0] mem_q [FIFO_DEPTH];
  logic [18:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [18:0] duty_q, duty_d, target_q, target_d, diff, cmd_clamp;
  logic [HW-1:0] hold_q, hold_d;
  logic at_q, at_d, verm_q, verm_d, push, pop;
  always_comb begin
    cmd_ready = lvl_q != FULL_N;
    cmd_clamp = cmd_duty < MIN_D ? MIN_D : (cmd_duty > MAX_D ? MAX_D : cmd_duty);
    push = cmd_valid && cmd_ready;
    pop = state_q == LOAD;
    diff = target_q > duty_q ? target_q - duty_q : duty_q - target_q;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = cmd_clamp;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    lvl_d = lvl_q + LW'(push) - LW'(pop);
    state_d = state_q;
    duty_d = duty_q;
    target_d = target_q;
    hold_d = hold_q;
    case (state_q)
      IDLE:
        if (lvl_q != '0) state_d = LOAD;
`ifdef SERVO_AUTOSWEEP_EN
        else begin
          state_d = RAMP;
          target_d = target_q <= MID_D ? MAX_D : MIN_D;
        end
`else
        else state_d = IDLE;
`endif
      LOAD: begin
        target_d = mem_q[rd_q];
        state_d = RAMP;
      end
      RAMP: begin
        hold_d = '0;
        if (frame_start) begin
          state_d = diff <= STEP_D ? HOLD : RAMP;
          duty_d = diff <= STEP_D ? target_q : (target_q > duty_q ? duty_q + STEP_D : duty_q - STEP_D);
        end
      end
      HOLD: begin
        hold_d = frame_start ? hold_q + HW'(1) : hold_q;
        if (hold_d == HOLD_N) state_d = IDLE;
      end
    endcase
    at_d = state_d == IDLE || state_d == HOLD;
    verm_d = state_d == RAMP;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      duty_q <= RST_D;
      target_q <= RST_D;
      hold_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      at_q <= 1'b1;
      verm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      target_q <= target_d;
      hold_q <= hold_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      at_q <= at_d;
      verm_q <= verm_d;
    end
  assign duty = duty_q;
  assign busy = state_q != IDLE || lvl_q != '0;
  assign at_target = at_q;
  assign fifo_level = lvl_q;
  assign led_verde = at_q;
  assign led_verm = verm_q;
endmodule
